// File: rtl/clk_div_seq_pkg.sv
// clk_div_seq_pkg
//   Shared definitions for the clock divider / LED sequencer slice:
//   mode FSM encoding, LFSR seed, and maximal-length Fibonacci tap masks
//   selectable by LFSR width (3..16).
package clk_div_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_ALL_ON = 2'd1,
        ST_RUN_A  = 2'd2,
        ST_RUN_B  = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'h0001;

    // Bit i of the mask selects register bit i as a feedback tap.
    // Feedback is the XOR of the tapped bits, shifted in at bit 0.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] mask;
        case (width)
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0829;
            13:      mask = 16'h100D;
            14:      mask = 16'h2015;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/clk_div_seq_chan.sv
// clk_div_chan
//   One divider channel: latches the ratio at each period boundary, counts
//   0..N-1, and produces a 50% duty divided clock plus a one-cycle tick at
//   the start of every period. Odd ratios get an extra half period of high
//   time from a falling-edge copy of the posedge high term.
//
//   Ports
//     clock_in  in   clock
//     reset     in   asynchronous active-low reset
//     div       in   requested divide ratio (0/1 = channel idle)
//     clk_div   out  divided clock
//     tick      out  one-cycle pulse coincident with clk_div rising
module clk_div_chan #(
    parameter int DIV_W = 4
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    output logic             clk_div,
    output logic             tick
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, cnt_nx;
    logic [DIV_W-1:0] n_q, n_nx;
    logic             run_q, run_nx;
    logic             odd_q;
    logic             hi_q, hi_nx;
    logic             tick_q, tick_nx;
    logic             fe_q;
    logic             wrap;

    // The ratio is only looked at on a period boundary; an idle channel
    // treats every cycle as a boundary so a valid ratio starts right away.
    always_comb begin
        cnt_nx = cnt_q;
        n_nx   = n_q;
        run_nx = run_q;
        wrap   = !run_q || (cnt_q == n_q - ONE);
        if (wrap) begin
            cnt_nx = '0;
            if ((div >> 1) != '0) begin
                run_nx = 1'b1;
                n_nx   = div;
            end else begin
                run_nx = 1'b0;
                n_nx   = '0;
            end
        end else begin
            cnt_nx = cnt_q + ONE;
        end
        // N>>1 is N/2 for even N and (N-1)/2 for odd N.
        hi_nx   = run_nx && (cnt_nx < (n_nx >> 1));
        tick_nx = run_nx && (cnt_nx == '0);
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            n_q    <= '0;
            run_q  <= 1'b0;
            odd_q  <= 1'b0;
            hi_q   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_nx;
            n_q    <= n_nx;
            run_q  <= run_nx;
            odd_q  <= run_nx & n_nx[0];
            hi_q   <= hi_nx;
            tick_q <= tick_nx;
        end
    end

    always_ff @(negedge clock_in or negedge reset) begin
        if (!reset) begin
            fe_q <= 1'b0;
        end else begin
            fe_q <= hi_q;
        end
    end

    // At a ratio change fe_q holds the last-count value (always low), so
    // switching odd_q there cannot produce a stray half pulse.
    assign clk_div = hi_q | (fe_q & odd_q);
    assign tick    = tick_q;

endmodule

// File: rtl/clk_div_seq.sv
// clk_div_seq
//   Two-channel clock divider with a push-button driven LED sequencer.
//   The button is synchronised and debounced; each debounced press steps
//   the mode FSM. In the run modes an LFSR advances on the selected
//   channel's tick and its low bits drive the LEDs.
//
//   state | meaning
//   ------+--------------------------------------------
//   INIT  | after reset, LEDs off, LFSR held
//   ALL_ON| all LEDs on, LFSR held
//   RUN_A | LEDs show LFSR, LFSR steps on tick_a
//   RUN_B | LEDs show LFSR, LFSR steps on tick_b
//
//   Ports
//     clock_in   in   clock
//     reset      in   asynchronous active-low reset
//     advance    in   raw active-low push button (asynchronous)
//     div_a/b    in   divide ratios for channels A/B
//     clk_div_a/b out divided clocks
//     tick_a/b   out  one-cycle period ticks
//     led        out  LED pattern (registered)
//     state      out  current mode
module clk_div_seq
    import clk_div_seq_pkg::*;
#(
    parameter int DIV_W   = 4,
    parameter int LFSR_W  = 8,
    parameter int LED_W   = 3,
    parameter int DEB_CYC = 16
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             advance,
    input  logic [DIV_W-1:0] div_a,
    input  logic [DIV_W-1:0] div_b,
    output logic             clk_div_a,
    output logic             clk_div_b,
    output logic             tick_a,
    output logic             tick_b,
    output logic [LED_W-1:0] led,
    output logic [1:0]       state
);

    localparam int                DEB_W    = $clog2(DEB_CYC + 1);
    localparam logic [DEB_W-1:0]  DEB_LOAD = DEB_W'(DEB_CYC - 1);
    localparam logic [LFSR_W-1:0] TAPS     = LFSR_W'(lfsr_taps(LFSR_W));
    localparam logic [LFSR_W-1:0] SEED     = LFSR_W'(LFSR_SEED);

    clk_div_chan #(.DIV_W(DIV_W)) u_chan_a (
        .clock_in (clock_in),
        .reset    (reset),
        .div      (div_a),
        .clk_div  (clk_div_a),
        .tick     (tick_a)
    );

    clk_div_chan #(.DIV_W(DIV_W)) u_chan_b (
        .clock_in (clock_in),
        .reset    (reset),
        .div      (div_b),
        .clk_div  (clk_div_b),
        .tick     (tick_b)
    );

    logic             adv_s1, adv_s2;
    logic             deb_level_q, deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q;
    logic             press;

    // Synchroniser and debounced level reset to the released (high) level.
    // Because the synchroniser also starts released, the cleared counter is
    // always reloaded before the first differing sample is seen.
    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            adv_s1      <= 1'b1;
            adv_s2      <= 1'b1;
            deb_level_q <= 1'b1;
            deb_prev_q  <= 1'b1;
            deb_cnt_q   <= '0;
        end else begin
            adv_s1     <= advance;
            adv_s2     <= adv_s1;
            deb_prev_q <= deb_level_q;
            if (adv_s2 == deb_level_q) begin
                deb_cnt_q <= DEB_LOAD;
            end else if (deb_cnt_q == '0) begin
                deb_level_q <= adv_s2;
                deb_cnt_q   <= DEB_LOAD;
            end else begin
                deb_cnt_q <= deb_cnt_q - DEB_W'(1);
            end
        end
    end

    assign press = deb_prev_q & ~deb_level_q;

    state_t            state_q, state_nx;
    logic [LFSR_W-1:0] lfsr_q, lfsr_nx;
    logic [LED_W-1:0]  led_q, led_nx;
    logic              shift_en;

    always_comb begin
        state_nx = state_q;
        if (press) begin
            case (state_q)
                ST_INIT:   state_nx = ST_ALL_ON;
                ST_ALL_ON: state_nx = ST_RUN_A;
                ST_RUN_A:  state_nx = ST_RUN_B;
                ST_RUN_B:  state_nx = ST_RUN_A;
                default:   state_nx = ST_INIT;
            endcase
        end

        // Shift enable follows the state before any same-cycle press.
        shift_en = ((state_q == ST_RUN_A) && tick_a) ||
                   ((state_q == ST_RUN_B) && tick_b);
        lfsr_nx = lfsr_q;
        if (lfsr_q == '0) begin
            lfsr_nx = SEED;
        end else if (shift_en) begin
            lfsr_nx = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
        end

        case (state_q)
            ST_INIT:   led_nx = '0;
            ST_ALL_ON: led_nx = '1;
            default:   led_nx = lfsr_q[LED_W-1:0];
        endcase
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q <= ST_INIT;
            lfsr_q  <= SEED;
            led_q   <= '0;
        end else begin
            state_q <= state_nx;
            lfsr_q  <= lfsr_nx;
            led_q   <= led_nx;
        end
    end

    assign led   = led_q;
    assign state = state_q;

endmodule

// File: doc/clk_div_seq.md
CLK_DIV_SEQ -- requirements
Module: clk_div_seq

Interface
REQ-001 Parameter DIV_W, default 4, width of each divide-ratio input (ratios up to 2^DIV_W-1).
REQ-002 Parameter LFSR_W, default 8, LFSR register width (legal 3..16).
REQ-003 Parameter LED_W, default 3, LED output width (LED_W <= LFSR_W).
REQ-004 Parameter DEB_CYC, default 16, debounce stability count in clock_in cycles.
REQ-005 clock_in  in  1  single clock; all logic SHALL use this clock only, rising edge except REQ-013.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 advance  in  1  raw active-low push button, asynchronous to clock_in.
REQ-008 div_a  in  DIV_W  divide ratio, channel A.
REQ-009 div_b  in  DIV_W  divide ratio, channel B.
REQ-010 clk_div_a  out  1  clock_in divided by div_a, 50% duty.
REQ-011 clk_div_b  out  1  clock_in divided by div_b, 50% duty.
REQ-012 tick_a / tick_b  out  1 each  one-cycle pulse per divided period; led  out  LED_W  pattern; state  out  2  current mode.

Function
REQ-013 Each channel SHALL hold a counter cnt cycling 0..N-1 (N = latched ratio); even N: output high while cnt < N/2; odd N: output = posedge term (cnt < (N-1)/2) OR that term re-registered on falling edge, giving high time N/2 clock_in periods exactly.
REQ-014 tick_x SHALL assert for exactly one clock_in cycle when cnt == 0, coincident with the rising edge of clk_div_x.
REQ-015 div_x SHALL be sampled only when cnt wraps to 0; mid-period changes SHALL NOT shorten or stretch the current period.
REQ-016 Ratio 0 or 1 SHALL hold clk_div_x low and tick_x low; a later ratio >= 2 SHALL start at cnt = 0 on the next clock.
REQ-017 advance SHALL pass a 2-flop synchroniser, then a debouncer accepting a new level only after DEB_CYC consecutive equal samples.
REQ-018 A press event SHALL be one cycle on the debounced high-to-low transition; holding the button SHALL generate no further events.
REQ-019 FSM states: INIT=0, ALL_ON=1, RUN_A=2, RUN_B=3; on press event: INIT->ALL_ON, ALL_ON->RUN_A, RUN_A->RUN_B, RUN_B->RUN_A.
REQ-020 led SHALL be 0 in INIT, all ones in ALL_ON, LFSR[LED_W-1:0] in RUN_A and RUN_B; led SHALL be registered (one-cycle latency from state/LFSR change).
REQ-021 LFSR SHALL be maximal-length Fibonacci, shifting once per tick_a in RUN_A and per tick_b in RUN_B, holding in INIT/ALL_ON.
REQ-022 An all-zero LFSR value SHALL reload seed 1 on the next cycle.
REQ-023 A press event coinciding with a tick SHALL apply both: LFSR shifts with the old state's channel, state updates the same cycle.
REQ-024 The mode FSM SHALL never depend on the divided clocks as clocks; all state and LFSR logic SHALL run on clock_in with tick enables.

Reset
REQ-025 reset low SHALL immediately clear all counters, synchroniser and debounce flops (debounced level = released), falling-edge flops, clk_div_x, tick_x, led to 0, state to INIT, LFSR to seed 1.
REQ-026 reset asserted mid-period or mid-debounce SHALL discard all progress; after release, channels restart at cnt = 0 with ratio sampled on the first clock.

Structure
REQ-027 Package clk_div_seq_pkg SHALL hold the state encoding, LFSR seed constant and a tap-mask function indexed by LFSR_W.
REQ-028 One sub-module clk_div_chan (counter, ratio latch, odd-duty falling-edge flop, tick) SHALL be instantiated twice.
REQ-029 Debouncer, FSM and LFSR SHALL live in clk_div_seq.

Verification
REQ-030 div_a=4 -> clk_div_a high 2 / low 2 clock_in cycles, tick_a every 4 cycles.
REQ-031 div_b=5 -> clk_div_b high exactly 2.5 periods, low 2.5, measured on both edges of clock_in.
REQ-032 advance low for DEB_CYC-1 cycles with 3 bounce glitches -> no state change; held low DEB_CYC+3 cycles -> exactly one step INIT->ALL_ON, led=3'b111.
REQ-033 Four clean presses -> state sequence 1,2,3,2; in RUN_A with div_a=3, LFSR_W=8 the led steps through seed-1 sequence once per tick_a, matching a reference model for 255 ticks with no repeat before 255.
REQ-034 div_a changed 4->7 at cnt=1 -> current period completes at 4 cycles, next period 7 cycles; div_a=1 -> clk_div_a and tick_a stay low.
REQ-035 reset pulsed low mid-period in RUN_B -> outputs 0 asynchronously, state INIT, led 0; after release the first tick_a occurs on the first clock with cnt=0.
